// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the 3x3 window sequencer: pixel/window widths,
// slot bit offsets inside the 108-bit window word, and the frame FSM states.
package filter_ctrl_pkg;

    localparam int PIX_W = 12;
    localparam int WIN_W = 9 * PIX_W;

    localparam int CENTER_LSB    = 96;
    localparam int LEFT_LSB      = 84;
    localparam int RIGHT_LSB     = 72;
    localparam int UP_LSB        = 60;
    localparam int DOWN_LSB      = 48;
    localparam int UPLEFT_LSB    = 36;
    localparam int UPRIGHT_LSB   = 24;
    localparam int DOWNLEFT_LSB  = 12;
    localparam int DOWNRIGHT_LSB = 0;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/filter_window_controller_line_buffer.sv
// Single-port line store, one word per image column holding {line r-2, line r-1}.
// The old word is read combinationally and replaced at the clock edge (read-before-write).
module line_buffer #(
    parameter int DEPTH = 160,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/filter_window_controller.sv
// Raster-stream to padded 3x3 window sequencer with start/busy/done framing.
// Define WIN_BORDER_REPLICATE_EN to pad with the center pixel instead of zero.
module filter_window_controller
    import filter_ctrl_pkg::*;
#(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIN_W-1:0] win_data,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d, out_col_q, out_col_d;
    logic [RW-1:0]         row_q, row_d, out_row_q, out_row_d;
    logic [2:0][PIX_W-1:0] lcol_q, lcol_d, ccol_q, ccol_d, new_col;
    logic                  win_valid_q, win_valid_d, done_q, done_d;
    logic [WIN_W-1:0]      win_data_q, win_data_d, win_next;
    logic [2*PIX_W-1:0]    lb_rdata, lb_wdata;
    logic                  slot_free, accepting, advance, emit;
    logic                  has_l, has_r, has_u, has_d;
    pixel_t                pad;

    // Incoming column, index 2 = oldest line; during FLUSH the bottom row is off-frame.
    assign new_col[2] = lb_rdata[2*PIX_W-1:PIX_W];
    assign new_col[1] = lb_rdata[PIX_W-1:0];
    assign new_col[0] = (state_q == FLUSH) ? '0 : in_pixel;
    assign lb_wdata   = {new_col[1], new_col[0]};

    line_buffer #(
        .DEPTH (IMG_W),
        .AW    (CW),
        .DW    (2 * PIX_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (advance),
        .addr  (col_q),
        .wdata (lb_wdata),
        .rdata (lb_rdata)
    );

    // Window about to be emitted: columns lcol_q | ccol_q | new_col, masked by its center position.
    always_comb begin
`ifdef WIN_BORDER_REPLICATE_EN
        pad = ccol_q[1];
`else
        pad = '0;
`endif
        has_l = (out_col_q != '0);
        has_r = (out_col_q != COL_LAST);
        has_u = (out_row_q != '0);
        has_d = (out_row_q != ROW_LAST);

        win_next = '0;
        win_next[CENTER_LSB    +: PIX_W] = ccol_q[1];
        win_next[LEFT_LSB      +: PIX_W] = has_l ? lcol_q[1] : pad;
        win_next[RIGHT_LSB     +: PIX_W] = has_r ? new_col[1] : pad;
        win_next[UP_LSB        +: PIX_W] = has_u ? ccol_q[2] : pad;
        win_next[DOWN_LSB      +: PIX_W] = has_d ? ccol_q[0] : pad;
        win_next[UPLEFT_LSB    +: PIX_W] = (has_u && has_l) ? lcol_q[2] : pad;
        win_next[UPRIGHT_LSB   +: PIX_W] = (has_u && has_r) ? new_col[2] : pad;
        win_next[DOWNLEFT_LSB  +: PIX_W] = (has_d && has_l) ? lcol_q[0] : pad;
        win_next[DOWNRIGHT_LSB +: PIX_W] = (has_d && has_r) ? new_col[0] : pad;
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        lcol_d      = lcol_q;
        ccol_d      = ccol_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        done_d      = 1'b0;
        slot_free   = !win_valid_q || win_ready;
        accepting   = ((state_q == FILL) || (state_q == STREAM)) && slot_free;
        advance     = 1'b0;
        emit        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    col_d     = '0;
                    row_d     = '0;
                    out_col_d = '0;
                    out_row_d = '0;
                end
            end
            FILL:   advance = in_valid && accepting;
            STREAM: begin
                advance = in_valid && accepting;
                emit    = advance;
            end
            FLUSH: begin
                advance = slot_free;
                emit    = advance;
            end
            DONE: begin
                if (win_valid_q && win_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end

        if (advance) begin
            lcol_d = ccol_q;
            ccol_d = new_col;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // Pixel (1,0) completes the IMG_W+1 fill; (H-1,W-1) is the last real input.
            if ((state_q == FILL) && (row_q == RW'(1)) && (col_q == '0)) begin
                state_d = STREAM;
            end
            if ((state_q == STREAM) && (row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                state_d = FLUSH;
            end
            if ((state_q == FLUSH) && (out_row_q == ROW_LAST) && (out_col_q == COL_LAST)) begin
                state_d = DONE;
            end
        end

        if (emit) begin
            win_valid_d = 1'b1;
            win_data_d  = win_next;
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                out_row_d = out_row_q + 1'b1;
            end else begin
                out_col_d = out_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            lcol_q      <= '0;
            ccol_q      <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            lcol_q      <= lcol_d;
            ccol_q      <= ccol_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            done_q      <= done_d;
        end
    end

    assign in_ready   = accepting;
    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

endmodule

// File: doc/filter_window_controller.md
# filter_window_controller

Sequencer that feeds the 3x3 neighbourhood filters of the image pipeline. It accepts a raster-order stream of 12-bit RGB444 pixels and holds the two previous image lines in line buffers. For every pixel of the frame it emits a 108-bit 3x3 window, padded at the image borders. It runs a start/busy/done frame protocol and uses valid/ready handshakes on both sides, so the downstream filter stage can stall it.

## Interface
Parameters:
- IMG_W, 160, pixels per line (>= 3)
- IMG_H, 120, lines per frame (>= 3)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when idle
- in_pixel  in  12  RGB444 pixel, R[11:8] G[7:4] B[3:0]
- in_valid  in  1  in_pixel valid
- in_ready  out  1  controller accepts in_pixel this cycle
- win_data  out  108  window: [107:96] center, [95:84] left, [83:72] right, [71:60] up, [59:48] down, [47:36] upleft, [35:24] upright, [23:12] downleft, [11:0] downright
- win_valid  out  1  win_data valid
- win_ready  in  1  downstream accepts win_data
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last window is accepted

## Operation
- States:
  - IDLE -> FILL on start.
  - FILL accepts IMG_W+1 pixels and emits no windows, then goes to STREAM.
  - STREAM accepts the remaining IMG_W*IMG_H-(IMG_W+1) pixels and emits one window per accepted pixel.
  - FLUSH runs after the last input pixel. It emits IMG_W+1 windows with no input consumed; missing bottom and right pixels are padded.
  - DONE waits for the final window to be accepted, pulses frame_done, then returns to IDLE.
- "Advance" means one step of the window pipeline:
  - In FILL/STREAM it happens when in_valid && in_ready.
  - In FLUSH it happens when the output slot is free or is being drained (!win_valid || win_ready).
- Each advance shifts the 3x3 register window by one column and updates the line buffers with a read-before-write at column index col.
- Counters:
  - col and row track the input position and wrap col at IMG_W-1.
  - out_col and out_row track the center position of the emitted window.
- Borders: any neighbour outside 0..IMG_W-1 / 0..IMG_H-1, judged from out_col/out_row, is replaced by the pad value (see Configuration).
  - Border masking never uses pixels wrapped in from the adjacent line.
- Windows are emitted in raster order of the center pixel; IMG_W*IMG_H windows per frame.
- start is ignored while busy.
- in_pixel is ignored while in_ready=0.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: in_ready, win_valid, busy, frame_done and win_data all 0.
  - Counters: 0.
  - Line-buffer contents: don't care, since they are masked by border logic.
- busy rises the cycle after start and falls in the same cycle frame_done pulses.
- in_ready = (FILL || STREAM) && (!win_valid || win_ready), combinational.
- Window latency: the window for center (r,c) is registered in the cycle after the advance that accepts pixel (r+1,c+1), or after the matching FLUSH step. win_valid rises one cycle after that advance.
- While win_valid=1 && win_ready=0, win_data and win_valid hold stable and no advance occurs.
- Throughput: one window per cycle when in_valid and win_ready are held high.
- frame_done is asserted in the cycle after the last window's win_valid && win_ready handshake.
- Reset mid-frame: everything immediately returns to reset values; the partial frame is discarded.

## Configuration
- WIN_BORDER_REPLICATE_EN defined: out-of-frame neighbours take the center pixel value.
- WIN_BORDER_REPLICATE_EN undefined: out-of-frame neighbours are 12'h000 (zero padding).

## Structure
- Package filter_ctrl_pkg holds:
  - PIX_W=12 and WIN_W=108.
  - Slot bit offsets for center/left/right/up/down/upleft/upright/downleft/downright.
  - State enum {IDLE, FILL, STREAM, FLUSH, DONE}.
- Sub-module line_buffer: single-port RAM, IMG_W deep x 24 bits, holding line r-1 and line r-2 packed. It reads the old word and writes the new one in one cycle at the same address.
- The controller instantiates one line_buffer.

## Test plan
Common setup: IMG_W=4, IMG_H=3, pixels 0x001..0x00C in raster order, win_ready=1, zero padding unless stated otherwise.
- Basic run -> exactly 12 windows. Window for (1,1): center 006, left 005, right 007, up 002, down 00A, upleft 001, upright 003, downleft 009, downright 00B.
- Corner (0,0), zero padding -> center 001, right 002, down 005, downright 006, all other slots 000. With WIN_BORDER_REPLICATE_EN, those other slots read 001.
- Bottom-right (2,3) during FLUSH -> center 00C, left 00B, up 008, upleft 007, others pad. No in_ready asserted during FLUSH.
- win_ready held low for 5 cycles mid-stream -> win_data and win_valid stable, in_ready=0. No window is lost or duplicated, and the sequence matches the basic run.
- start pulsed while busy, then frame completes -> start ignored; a single frame_done pulse after the 12th handshake; busy=0 in the same cycle.
- reset asserted after 6 input pixels -> all outputs 0 and state IDLE. A new start then produces a correct full frame.
